sdram_wide_bridge: RTL

- Responder end of the arbiter's 128-bit SDRAM master port (ar_*).
- Accepts one 128-bit read or write per request.
- Splits each request into 8 x 16-bit Avalon-MM beats to the on-board SDRAM controller, reassembles read data, and returns a one-cycle ar_ac on completion.
- Sits between the SDRAM arbiter and the 16-bit SDRAM controller.

---
 rtl/sdram_wide_bridge_pkg.sv | 33 +++
 rtl/sdram_wide_bridge_if.sv | 41 ++++
 rtl/sdram_wide_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sdram_wide_bridge_pkg.sv
// Shared constants, state encodings and beat helpers for the 128-bit to 16-bit SDRAM bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_bridge_pkg;

   localparam int BEATS  = 8;            // 16-bit beats per 128-bit word
   localparam int AW_UP  = 22;           // upstream 128-bit word address width
   localparam int AW_DN  = AW_UP + 3;    // downstream halfword address width
   localparam int LANE_W = 16;           // width of one beat / lane

   localparam logic [2:0] LAST_BEAT = 3'd7;
   localparam logic [3:0] NO_BEAT   = 4'd8;  // "no further beat" marker from next_beat()

   // FSM encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_ACK   = 3'd3;
   localparam logic [2:0] ST_COOL  = 3'd4;

   // Lowest beat index >= start whose byte-enable pair is non-zero, or NO_BEAT.
   function automatic logic [3:0] next_beat(input logic [15:0] be, input logic [3:0] start);
      logic [3:0] res;
      res = NO_BEAT;
      for (int i = BEATS - 1; i >= 0; i--) begin
         if ((4'(i) >= start) && (be[2*i +: 2] != 2'b00)) begin
            res = 4'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sdram_wide_bridge_if.sv
// Bundle of the arbiter-side (ar_*) and SDRAM-controller-side (av_*) signals of the bridge.
// Latency: n/a (wiring only).
// Backpressure: ar side is level request / one-cycle ack; av side is Avalon-MM waitrequest.
interface sdram_wide_bridge_if;
   import sdram_bridge_pkg::*;

   // arbiter side
   logic [AW_UP-1:0]  ar_addr;
   logic [15:0]       ar_be;
   logic              ar_read;
   logic              ar_write;
   logic [127:0]      ar_wrdata;
   logic [127:0]      ar_rddata;
   logic              ar_ac;

   // SDRAM controller side
   logic [AW_DN-1:0]  av_address;
   logic [1:0]        av_byteenable;
   logic              av_read;
   logic              av_write;
   logic [LANE_W-1:0] av_writedata;
   logic [LANE_W-1:0] av_readdata;
   logic              av_readdatavalid;
   logic              av_waitrequest;

   // bridge view
   modport slave (
      input  ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
      output ar_rddata, ar_ac,
      output av_address, av_byteenable, av_read, av_write, av_writedata,
      input  av_readdata, av_readdatavalid, av_waitrequest
   );

   // environment view (arbiter + controller)
   modport master (
      output ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
      input  ar_rddata, ar_ac,
      input  av_address, av_byteenable, av_read, av_write, av_writedata,
      output av_readdata, av_readdatavalid, av_waitrequest
   );
endinterface

// File: rtl/sdram_wide_bridge.sv
// Splits 128-bit arbiter reads/writes into 8 x 16-bit Avalon-MM beats and reassembles read data.
// Latency: zero-stall full write acks 9 cycles after request; reads ack on the cycle after the 8th data beat.
// Backpressure: av_* held stable under av_waitrequest; arbiter request held until the one-cycle ar_ac.
module sdram_wide_bridge
   import sdram_bridge_pkg::*;
(
   input  logic clk,
   input  logic reset,
   sdram_wide_bridge_if.slave bus
);

   logic [2:0]        r_state;
   logic [AW_UP-1:0]  r_addr;
   logic [15:0]       r_be;
   logic [127:0]      r_wdat;
   logic [2:0]        r_icnt;
   logic [2:0]        r_rcnt;
   logic [127:0]      r_rbuf;
   logic [127:0]      r_rddata;
   logic              r_ac;
   logic [AW_DN-1:0]  r_av_address;
   logic [1:0]        r_av_byteenable;
   logic              r_av_read;
   logic              r_av_write;
   logic [LANE_W-1:0] r_av_writedata;

   logic [3:0]        w_first_beat;
   logic [2:0]        w_first_idx;
   logic [LANE_W-1:0] w_first_wdat;
   logic [1:0]        w_first_be;
   logic [3:0]        w_next_beat;
   logic [2:0]        w_next_idx;
   logic [LANE_W-1:0] w_next_wdat;
   logic [1:0]        w_next_be;
   logic              w_wr_accept;
   logic              w_rd_accept;
   logic [127:0]      w_rbuf_nxt;

   // First write beat comes straight from the request so beat 0 is on the bus the cycle after it is seen.
   assign w_first_beat = next_beat(bus.ar_be, 4'd0);
   assign w_first_idx  = w_first_beat[2:0];
   assign w_first_wdat = bus.ar_wrdata[{w_first_idx, 4'b0000} +: LANE_W];
   assign w_first_be   = bus.ar_be[{w_first_idx, 1'b0} +: 2];

   // Following write beats skip all-zero byte-enable pairs entirely.
   assign w_next_beat  = next_beat(r_be, {1'b0, r_icnt} + 4'd1);
   assign w_next_idx   = w_next_beat[2:0];
   assign w_next_wdat  = r_wdat[{w_next_idx, 4'b0000} +: LANE_W];
   assign w_next_be    = r_be[{w_next_idx, 1'b0} +: 2];

   assign w_wr_accept  = r_av_write & ~bus.av_waitrequest;
   assign w_rd_accept  = r_av_read  & ~bus.av_waitrequest;

   // Insert the incoming read beat into its lane of the assembly buffer.
   always_comb begin
      w_rbuf_nxt = r_rbuf;
      w_rbuf_nxt[{r_rcnt, 4'b0000} +: LANE_W] = bus.av_readdata;
   end

   // Request FSM, beat issue and read reassembly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_be            <= '0;
         r_wdat          <= '0;
         r_icnt          <= '0;
         r_rcnt          <= '0;
         r_rbuf          <= '0;
         r_rddata        <= '0;
         r_ac            <= 1'b0;
         r_av_address    <= '0;
         r_av_byteenable <= '0;
         r_av_read       <= 1'b0;
         r_av_write      <= 1'b0;
         r_av_writedata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.ar_read || bus.ar_write) begin
                  r_addr <= bus.ar_addr;
                  r_be   <= bus.ar_be;
                  r_wdat <= bus.ar_wrdata;
                  r_rcnt <= '0;
               end
               // read takes priority when both requests are raised together
               if (bus.ar_read) begin
                  r_state         <= ST_READ;
                  r_icnt          <= '0;
                  r_av_read       <= 1'b1;
                  r_av_address    <= {bus.ar_addr, 3'b000};
                  r_av_byteenable <= 2'b11;
               end else if (bus.ar_write) begin
                  r_state <= ST_WRITE;
                  r_icnt  <= '0;
                  if (w_first_beat != NO_BEAT) begin
                     r_icnt          <= w_first_idx;
                     r_av_write      <= 1'b1;
                     r_av_address    <= {bus.ar_addr, w_first_idx};
                     r_av_writedata  <= w_first_wdat;
                     r_av_byteenable <= w_first_be;
                  end
               end
            end

            ST_WRITE: begin
               if (!r_av_write) begin
                  // nothing enabled: single idle cycle, then acknowledge
                  r_state <= ST_ACK;
                  r_ac    <= 1'b1;
                  r_icnt  <= '0;
               end else if (w_wr_accept) begin
                  if (w_next_beat == NO_BEAT) begin
                     r_state    <= ST_ACK;
                     r_ac       <= 1'b1;
                     r_av_write <= 1'b0;
                     r_icnt     <= '0;
                  end else begin
                     r_icnt          <= w_next_idx;
                     r_av_address    <= {r_addr, w_next_idx};
                     r_av_writedata  <= w_next_wdat;
                     r_av_byteenable <= w_next_be;
                  end
               end
            end

            ST_READ: begin
               if (w_rd_accept) begin
                  if (r_icnt == LAST_BEAT) begin
                     r_av_read <= 1'b0;
                  end else begin
                     r_icnt       <= r_icnt + 3'd1;
                     r_av_address <= {r_addr, r_icnt + 3'd1};
                  end
               end
               // data beats may overlap issue; the 8th one completes the request
               if (bus.av_readdatavalid) begin
                  r_rbuf <= w_rbuf_nxt;
                  if (r_rcnt == LAST_BEAT) begin
                     r_rddata  <= w_rbuf_nxt;
                     r_ac      <= 1'b1;
                     r_state   <= ST_ACK;
                     r_rcnt    <= '0;
                     r_icnt    <= '0;
                     r_av_read <= 1'b0;
                  end else begin
                     r_rcnt <= r_rcnt + 3'd1;
                  end
               end
            end

            ST_ACK: begin
               r_ac    <= 1'b0;
               r_state <= ST_COOL;
            end

            // one dead cycle so a requester dropping one cycle after ar_ac is not re-served
            ST_COOL: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ar_rddata     = r_rddata;
   assign bus.ar_ac         = r_ac;
   assign bus.av_address    = r_av_address;
   assign bus.av_byteenable = r_av_byteenable;
   assign bus.av_read       = r_av_read;
   assign bus.av_write      = r_av_write;
   assign bus.av_writedata  = r_av_writedata;

endmodule
